// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer
//
// Arbitrates the external bus between the instruction-fetch (IF) and load/store (LS) ports.
// It also sequences each granted transfer as one 8 T-state bus cycle. Memory wait states are
// inserted at T6 while stall_ is low. Read data and a one-cycle done pulse are returned to the
// owner of the bus cycle.
//
// Ports:
//   clk, rst_          core clock, asynchronous active-low reset
//   if_req, if_addr    IF read request and address
//   ls_req, ls_we,     LS request, direction (1 = write), address and write data
//   ls_addr, ls_wdata
//   stall_, mem_rdata  memory ready (low = wait) and memory read data
//   t_state, busint,   T-state, bus-cycle-active, direction (1 = read), latched address
//   dtr_, ADDR
//   wdata              latched write data
//   if_gnt, ls_gnt     owner of the current bus cycle
//   if_done, ls_done   one-cycle completion pulse in T7
//   rdata              captured read data
module bus_cycle_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  input  logic             stall_,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [2:0]       t_state,
  output logic             busint,
  output logic             dtr_,
  output logic [WIDTH-1:0] ADDR,
  output logic [WIDTH-1:0] wdata,
  output logic             if_gnt,
  output logic             ls_gnt,
  output logic             if_done,
  output logic             ls_done,
  output logic [WIDTH-1:0] rdata
);

  typedef enum logic [1:0] {StIdle, StCycle, StWait} state_e;

  state_e           state_q, state_d;
  logic [2:0]       t_q, t_d;
  logic             dtr_q, dtr_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             if_gnt_q, if_gnt_d;
  logic             ls_gnt_q, ls_gnt_d;
  logic             if_done_q, if_done_d;
  logic             ls_done_q, ls_done_d;
  logic             last_ls_q, last_ls_d;  // 0 = IF owned the last cycle

  logic at_t7, arb_en, if_eff, ls_eff, pick_if, pick_ls, grant;

  always_comb begin
    // In T7 the current owner's request is ignored so back-to-back cycles always alternate.
    at_t7   = (state_q == StCycle) && (t_q == 3'd7);
    arb_en  = (state_q == StIdle) || at_t7;
    if_eff  = if_req & ~(at_t7 & if_gnt_q);
    ls_eff  = ls_req & ~(at_t7 & ls_gnt_q);
    pick_ls = ls_eff & (~if_eff | ~last_ls_q);
    pick_if = if_eff & ~pick_ls;
    grant   = arb_en & (pick_if | pick_ls);

    state_d   = state_q;
    t_d       = t_q;
    dtr_d     = dtr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    if_gnt_d  = if_gnt_q;
    ls_gnt_d  = ls_gnt_q;
    if_done_d = 1'b0;
    ls_done_d = 1'b0;
    last_ls_d = last_ls_q;

    unique case (state_q)
      StIdle: ;
      StCycle: begin
        if (t_q == 3'd7) begin
          state_d  = StIdle;
          t_d      = 3'd0;
          if_gnt_d = 1'b0;
          ls_gnt_d = 1'b0;
          dtr_d    = 1'b1;
        end else if (t_q == 3'd6) begin
          if (stall_) begin
            t_d       = 3'd7;
            if_done_d = if_gnt_q;
            ls_done_d = ls_gnt_q;
            if (dtr_q) rdata_d = mem_rdata;
          end else begin
            state_d = StWait;
          end
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      StWait: begin
        if (stall_) begin
          state_d   = StCycle;
          t_d       = 3'd7;
          if_done_d = if_gnt_q;
          ls_done_d = ls_gnt_q;
          if (dtr_q) rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = StIdle;
        t_d     = 3'd0;
      end
    endcase

    // A grant overrides the return to idle taken in T7.
    if (grant) begin
      state_d   = StCycle;
      t_d       = 3'd0;
      if_gnt_d  = pick_if;
      ls_gnt_d  = pick_ls;
      last_ls_d = pick_ls;
      addr_d    = pick_ls ? ls_addr : if_addr;
      dtr_d     = pick_ls ? ~ls_we : 1'b1;
      if (pick_ls && ls_we) wdata_d = ls_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= StIdle;
      t_q       <= 3'd0;
      dtr_q     <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      if_gnt_q  <= 1'b0;
      ls_gnt_q  <= 1'b0;
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      last_ls_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      dtr_q     <= dtr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      if_gnt_q  <= if_gnt_d;
      ls_gnt_q  <= ls_gnt_d;
      if_done_q <= if_done_d;
      ls_done_q <= ls_done_d;
      last_ls_q <= last_ls_d;
    end
  end

  assign t_state = t_q;
  assign busint  = (state_q != StIdle);
  assign dtr_    = dtr_q;
  assign ADDR    = addr_q;
  assign wdata   = wdata_q;
  assign rdata   = rdata_q;
  assign if_gnt  = if_gnt_q;
  assign ls_gnt  = ls_gnt_q;
  assign if_done = if_done_q;
  assign ls_done = ls_done_q;

endmodule

// File: doc/bus_cycle_sequencer.md
# bus_cycle_sequencer

Generates the 3-bit T-state sequence and bus-cycle controls (`t_state`, `busint`, `dtr_`, `ADDR`) that drive the non-multiplexed bus interface unit. Arbitrates the single external bus between the instruction-fetch port (IF) and the load/store port (LS) of the RV32I core. Each granted transfer is one 8-T-state bus cycle, stretched by memory wait states via `stall_`. The block returns read data and a done pulse to the winning requester.

## Interface
Parameters:
- `WIDTH`, 32, address and data width

Ports:
- `clk` in 1: single core clock; all state changes on the rising edge
- `rst_` in 1: reset, asynchronous, active-low
- `if_req` in 1: IF read request; held high until `if_done`
- `if_addr` in WIDTH: IF read address
- `ls_req` in 1: LS request; held high until `ls_done`
- `ls_we` in 1: LS direction; 1 = write, 0 = read
- `ls_addr` in WIDTH: LS address
- `ls_wdata` in WIDTH: LS write data
- `stall_` in 1: memory ready; low inserts wait states
- `mem_rdata` in WIDTH: data bus from memory
- `t_state` out 3: current T-state, to the BIU
- `busint` out 1: bus cycle in progress, to the BIU
- `dtr_` out 1: direction to the BIU; 1 = read, 0 = write
- `ADDR` out WIDTH: latched bus address
- `wdata` out WIDTH: latched write data
- `if_gnt`, `ls_gnt` out 1 each: owner of the current bus cycle
- `if_done`, `ls_done` out 1 each: one-cycle completion pulse
- `rdata` out WIDTH: captured read data; valid while done is high

## Operation
- The FSM has three states:
  - IDLE: `busint`=0, `t_state`=0.
  - CYCLE: `t_state` counts 0→7.
  - WAIT: `t_state` is held at 6.
- Reset value of every output is 0, except `dtr_`=1. The internal `last_owner` resets to IF, so LS wins the first conflict.
- Arbitration happens in IDLE, or in the `t_state`=7 cycle.
  - With a single request, that requester wins.
  - With both requesting, the one that is not `last_owner` wins (alternating).
  - In the `t_state`=7 cycle, the current owner's request is ignored. The owner must drop its request the cycle after done. Back-to-back cycles are only possible between different owners.
- On the grant edge, the block latches the following, which stay stable through `t_state`=7:
  - `ADDR` ← winner's address
  - `dtr_` ← ~`ls_we`, or 1 for IF
  - `wdata` ← `ls_wdata`; it is unchanged for reads
  - `gnt` for the winner
- In CYCLE, `t_state` increments each clock. At `t_state`=6:
  - If `stall_`=0, go to WAIT and hold 6 until `stall_`=1.
  - If `stall_`=1 (in CYCLE or WAIT), advance to 7. For reads, capture `mem_rdata` into `rdata` on that edge.
- In the `t_state`=7 cycle, the owner's done is high for exactly that cycle and `busint` stays 1.
  - If the next winner exists, the next edge sets `t_state`=0 with the new owner's latches.
  - Otherwise the next edge returns to IDLE with `busint`=0, `gnt`=0, `dtr_`=1. `ADDR`, `wdata` and `rdata` hold their values.
- `stall_` is ignored in `t_state` 0–5 and 7.
- If the requester drops its request mid-cycle, the cycle still completes and done still pulses.
- Reset asserted mid-cycle aborts immediately to reset values. No done pulse is issued and `last_owner` returns to IF.
- `rdata` is not updated by write cycles.

## Timing
- From IDLE, a request sampled at edge k gives `busint`=1 and `t_state`=0 after edge k.
- With no stall, done is high 7 cycles after `t_state`=0, so the cycle occupies 8 clocks with `busint` high.
- Each cycle with `stall_`=0 at `t_state`=6 adds exactly 1 clock.
- Back-to-back cycles between different owners have no idle cycle: `t_state` goes 7 → 0.
- A same-owner re-request costs at least 1 IDLE clock.
- Done and `rdata` are registered outputs; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert `rst_`=0 mid-cycle at `t_state`=3 → `busint`=0, `t_state`=0, `dtr_`=1, `gnt`/done=0 immediately, with no done after release.
- **Single IF read:** `if_req` with `if_addr`=0x100, `mem_rdata`=0xDEADBEEF, `stall_`=1 → `t_state` 0..7, `ADDR`=0x100, `dtr_`=1, `if_done` pulses at `t_state`=7 with `rdata`=0xDEADBEEF, then IDLE.
- **LS write with 3 wait states:** `ls_we`=1, `ls_addr`=0x200, `ls_wdata`=0x12345678, `stall_`=0 for 3 clocks at `t_state`=6 → `dtr_`=0, `t_state` holds at 6 for 4 clocks, `ls_done` after 11 clocks total, `rdata` unchanged.
- **Simultaneous requests from reset:** both requests at once → LS is served first; IF starts at `t_state`=0 directly after LS `t_state`=7, with no idle cycle.
- **Continuous both-request:** both requesters re-request after done → grants alternate IF/LS/IF/LS.
- **Request drop:** `if_req` dropped at `t_state`=2 → the cycle completes and `if_done` still pulses.
